ppt_burst_sequencer: RTL

Pulse-train engine that sits directly downstream of the register map and drives the PPT output pin. It latches period, width and target pulse count on a run request. It emits exactly `target` pulses, or runs continuously when target is 0. It reports pulses completed, busy, done and configuration-error status back to the register map. All logic runs in the divided-clock domain.

---
 rtl/ppt_burst_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ppt_burst_sequencer.sv
// Pulse-train engine for the PPT pin: latches period/width/target on a run rise and
// emits a counted (or continuous) burst, reporting busy/done/error and pulses completed.
module ppt_burst_sequencer #(
  parameter int CW          = 16,
  parameter bit CLAMP_WIDTH = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [CW-1:0] period,
  input  logic [CW-1:0] width,
  input  logic [CW-1:0] target,
  output logic          pulse_out,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  output logic [CW-1:0] count_done
);

  typedef enum logic [2:0] {IDLE, LOAD, HI, LO, DONE, ERR} state_t;

  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] TWO  = CW'(2);
  localparam logic [CW-1:0] ONES = {CW{1'b1}};

  state_t        state_reg, state_next;
  logic          run_low_reg;
  logic [CW-1:0] p_reg, p_next;
  logic [CW-1:0] w_reg, w_next;
  logic [CW-1:0] t_reg, t_next;
  logic [CW-1:0] phase_reg, phase_next;
  logic [CW-1:0] count_reg, count_next;
  logic          pulse_reg, busy_reg, done_reg, err_reg;
  logic          start;

  // The history flag means "run was sampled low"; reset clears it so a run level
  // held high across reset release cannot start a burst until it drops first.
  assign start = run && run_low_reg;

  always_comb begin
    state_next = state_reg;
    p_next     = p_reg;
    w_next     = w_reg;
    t_next     = t_reg;
    phase_next = phase_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          p_next     = period;
          w_next     = width;
          t_next     = target;
          count_next = '0;
        end
      end
      LOAD: begin
        if (!run) begin
          state_next = IDLE;
        end else if (p_reg < TWO || w_reg == '0) begin
          state_next = ERR;
        end else if (w_reg >= p_reg) begin
          if (CLAMP_WIDTH) begin
            state_next = HI;
            w_next     = p_reg - ONE;
            phase_next = p_reg - TWO;
          end else begin
            state_next = ERR;
          end
        end else begin
          state_next = HI;
          phase_next = w_reg - ONE;
        end
      end
      HI: begin
        if (!run) begin
          state_next = IDLE;
        end else if (phase_reg == '0) begin
          state_next = LO;
          phase_next = p_reg - w_reg - ONE;
          // Saturation only matters in continuous mode; bounded bursts stop far earlier.
          if (count_reg != ONES) count_next = count_reg + ONE;
        end else begin
          phase_next = phase_reg - ONE;
        end
      end
      LO: begin
        if (!run) begin
          state_next = IDLE;
        end else if (phase_reg == '0) begin
          if (t_reg != '0 && count_reg == t_reg) begin
            state_next = DONE;
          end else begin
            state_next = HI;
            phase_next = w_reg - ONE;
          end
        end else begin
          phase_next = phase_reg - ONE;
        end
      end
      DONE: begin
        if (!run) state_next = IDLE;
      end
      ERR: begin
        count_next = '0;
        if (!run) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      run_low_reg <= 1'b0;
      p_reg       <= '0;
      w_reg       <= '0;
      t_reg       <= '0;
      phase_reg   <= '0;
      count_reg   <= '0;
      pulse_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      run_low_reg <= ~run;
      p_reg       <= p_next;
      w_reg       <= w_next;
      t_reg       <= t_next;
      phase_reg   <= phase_next;
      count_reg   <= count_next;
      // Flags are registered from the next state so they track the state register exactly.
      pulse_reg   <= (state_next == HI);
      busy_reg    <= (state_next == LOAD) || (state_next == HI) || (state_next == LO);
      done_reg    <= (state_next == DONE);
      err_reg     <= (state_next == ERR);
    end
  end

  assign pulse_out  = pulse_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign cfg_err    = err_reg;
  assign count_done = count_reg;

endmodule
